// File: rtl/binary_mul_sched.sv
// Round-robin scheduler sharing one serial 8x8 multiplier among NUM_REQ requesters.
// Grants one operand pair at a time, waits LATENCY cycles, returns product with requester ID.
module binary_mul_sched #(
    parameter int NUM_REQ = 4,
    parameter int LATENCY = 9,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_a,
    input  logic [8*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [15:0]          rsp_p,
    output logic [7:0]           mul_a,
    output logic [7:0]           mul_b,
    output logic                 mul_en,
    output logic                 mul_rst_n,
    input  logic [15:0]          mul_p,
    output logic                 busy,
    output logic [15:0]          ops_done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int CNTW = $clog2(LATENCY + 1);

    state_t          state;
    logic [IDW-1:0]  ptr;
    logic [CNTW-1:0] cnt;
    logic            grant_any;
    logic [IDW-1:0]  grant_idx;
    logic [IDW-1:0]  scan;

    // Scan from ptr+1 upward so the last winner gets lowest priority next time.
    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        scan      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan = IDW'((int'(ptr) + k) % NUM_REQ);
            if (!grant_any && req_valid[scan]) begin
                grant_any = 1'b1;
                grant_idx = scan;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (!rst && state == IDLE && grant_any)
            req_ready = NUM_REQ'(1) << grant_idx;
    end

    assign mul_rst_n = ~rst;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= IDW'(NUM_REQ - 1);
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_p     <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
            mul_en    <= 1'b0;
            busy      <= 1'b0;
            ops_done  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        mul_a  <= req_a[{grant_idx, 3'b000} +: 8];
                        mul_b  <= req_b[{grant_idx, 3'b000} +: 8];
                        rsp_id <= grant_idx;
                        ptr    <= grant_idx;
                        cnt    <= '0;
                        mul_en <= 1'b1;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (cnt == CNTW'(LATENCY)) begin
                        rsp_p     <= mul_p;
                        rsp_valid <= 1'b1;
                        mul_en    <= 1'b0;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        ops_done  <= ops_done + 16'd1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_binary_mul_sched.sv
// Self-checking bench for binary_mul_sched: behavioural multiplier, per-requester
// operand queues and a response scoreboard filled at each grant.
module tb_binary_mul_sched;

    localparam int NUM_REQ = 4;
    localparam int LATENCY = 9;
    localparam int IDW     = 2;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [15:0]    p;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_a;
    logic [8*NUM_REQ-1:0] req_b;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [15:0]          rsp_p;
    logic [7:0]           mul_a;
    logic [7:0]           mul_b;
    logic                 mul_en;
    logic                 mul_rst_n;
    logic [15:0]          mul_p;
    logic                 busy;
    logic [15:0]          ops_done;

    binary_mul_sched #(.NUM_REQ(NUM_REQ), .LATENCY(LATENCY), .IDW(IDW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_p(rsp_p),
        .mul_a(mul_a), .mul_b(mul_b), .mul_en(mul_en), .mul_rst_n(mul_rst_n),
        .mul_p(mul_p), .busy(busy), .ops_done(ops_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier model: product is valid only after LATENCY enabled cycles.
    int mcnt = 0;
    always @(posedge clk) begin
        if (!mul_rst_n || !mul_en) mcnt <= 0;
        else                       mcnt <= mcnt + 1;
    end
    assign mul_p = (mcnt >= LATENCY) ? ({8'h00, mul_a} * {8'h00, mul_b}) : 16'hDEAD;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    logic [7:0] qa[NUM_REQ][$];
    logic [7:0] qb[NUM_REQ][$];
    exp_t       sb[$];
    int         g_id[$];
    int         g_edge[$];
    int         r_p[$];
    logic [15:0] exp_ops = '0;
    int         stall_left = 0;
    int         last_grant = 0;
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b1;
    logic [IDW-1:0] prev_id = '0;
    logic [15:0]    prev_p = '0;

    task automatic push(input int i, input logic [7:0] a, input logic [7:0] b);
        qa[i].push_back(a);
        qb[i].push_back(b);
    endtask

    function automatic bit queues_empty();
        for (int i = 0; i < NUM_REQ; i++)
            if (qa[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    // Requester and consumer driver, updated just after each rising edge.
    initial begin
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                req_valid[i] = (qa[i].size() != 0);
                if (qa[i].size() != 0) begin
                    req_a[8*i +: 8] = qa[i][0];
                    req_b[8*i +: 8] = qb[i][0];
                end
            end
            if (rsp_valid && stall_left > 0) begin
                rsp_ready  = 1'b0;
                stall_left = stall_left - 1;
            end else begin
                rsp_ready = 1'b1;
            end
        end
    end

    // Monitor: sampled on the falling edge, describes what the next rising edge does.
    always @(negedge clk) begin
        if (cyc > 0) begin
            check("mul_rst_n", 32'(mul_rst_n), 32'(!rst));
            if (rst) begin
                check("ready_in_rst", 32'(req_ready), 32'h0);
                sb.delete();
                exp_ops    = '0;
                prev_valid = 1'b0;
                prev_ready = 1'b1;
            end else begin
                check("ops_done", 32'(ops_done), 32'(exp_ops));
                if (busy) check("ready_while_busy", 32'(req_ready), 32'h0);
                if (req_ready != '0) begin
                    check("ready_onehot", 32'($onehot(req_ready)), 32'h1);
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (req_ready[i] && req_valid[i]) begin
                            sb.push_back('{id: IDW'(i), p: 16'(qa[i][0]) * 16'(qb[i][0])});
                            void'(qa[i].pop_front());
                            void'(qb[i].pop_front());
                            g_id.push_back(i);
                            g_edge.push_back(cyc + 1);
                            last_grant = cyc + 1;
                        end
                    end
                end
                if (prev_valid && !prev_ready) begin
                    check("stall_valid", 32'(rsp_valid), 32'h1);
                    check("stall_id", 32'(rsp_id), 32'(prev_id));
                    check("stall_p", 32'(rsp_p), 32'(prev_p));
                end
                if (rsp_valid && !prev_valid)
                    check("rsp_latency", 32'(cyc - last_grant), 32'(LATENCY + 1));
                if (rsp_valid && rsp_ready) begin
                    if (sb.size() == 0) begin
                        check("rsp_unexpected", 32'h1, 32'h0);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check("rsp_id", 32'(rsp_id), 32'(e.id));
                        check("rsp_p", 32'(rsp_p), 32'(e.p));
                    end
                    r_p.push_back(int'(rsp_p));
                    exp_ops = exp_ops + 16'd1;
                end
                prev_valid = rsp_valid;
                prev_ready = rsp_ready;
                prev_id    = rsp_id;
                prev_p     = rsp_p;
            end
        end
    end

    task automatic wait_drain(input string tag, input int max_cyc);
        int  n;
        bit  done;
        n    = 0;
        done = 1'b0;
        while (!done && n < max_cyc) begin
            @(negedge clk);
            #1;
            n++;
            done = queues_empty() && sb.size() == 0 && !busy && !rsp_valid && req_valid == '0;
        end
        if (!done) check({tag, "_timeout"}, 32'h0, 32'h1);
    endtask

    task automatic check_rst_vals(input string tag);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
        check({tag, "_rsp_id"}, 32'(rsp_id), 32'h0);
        check({tag, "_rsp_p"}, 32'(rsp_p), 32'h0);
        check({tag, "_mul_a"}, 32'(mul_a), 32'h0);
        check({tag, "_mul_b"}, 32'(mul_b), 32'h0);
        check({tag, "_mul_en"}, 32'(mul_en), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_ops_done"}, 32'(ops_done), 32'h0);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #3 rst = 1'b0;
    endtask

    initial begin
        int gbase;
        int rbase;
        int t_grant;
        int n;
        int exp_order[5];
        int exp_prod[5];
        int bnd[4];

        // Reset with requester 0 already pending: no grant may appear while rst is high.
        push(0, 8'd13, 8'd11);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_rst_vals("init");
        @(posedge clk);
        #3 rst = 1'b0;

        // Single request: 13*11.
        rbase = r_p.size();
        wait_drain("single", 100);
        check("single_count", 32'(r_p.size() - rbase), 32'h1);
        if (r_p.size() > rbase) check("single_p", 32'(r_p[rbase]), 32'd143);
        check("single_ops", 32'(ops_done), 32'h1);

        // All requesters continuously valid, pointer back at NUM_REQ-1.
        pulse_reset();
        gbase = g_id.size();
        rbase = r_p.size();
        for (int i = 0; i < NUM_REQ; i++) push(i, 8'(i + 1), 8'd10);
        push(0, 8'd1, 8'd10);
        wait_drain("rr", 300);
        exp_order = '{0, 1, 2, 3, 0};
        exp_prod  = '{10, 20, 30, 40, 10};
        if (g_id.size() >= gbase + 5 && r_p.size() >= rbase + 5) begin
            for (int k = 0; k < 5; k++) begin
                check("rr_order", 32'(g_id[gbase + k]), 32'(exp_order[k]));
                check("rr_prod", 32'(r_p[rbase + k]), 32'(exp_prod[k]));
                if (k > 0) check("rr_spacing", 32'(g_edge[gbase + k] - g_edge[gbase + k - 1]), 32'd12);
            end
        end else begin
            check("rr_grants", 32'(g_id.size() - gbase), 32'd5);
        end

        // Backpressure: 5 stall cycles on the first response.
        stall_left = 5;
        gbase = g_id.size();
        push(2, 8'd7, 8'd9);
        push(3, 8'd6, 8'd6);
        wait_drain("bp", 300);
        if (g_id.size() >= gbase + 2) begin
            check("bp_first", 32'(g_id[gbase]), 32'd2);
            check("bp_spacing", 32'(g_edge[gbase + 1] - g_edge[gbase]), 32'd17);
        end else begin
            check("bp_grants", 32'(g_id.size() - gbase), 32'd2);
        end

        // Operand boundaries.
        rbase = r_p.size();
        push(0, 8'd255, 8'd255);
        push(1, 8'd0,   8'd200);
        push(2, 8'd1,   8'd255);
        push(3, 8'd128, 8'd2);
        wait_drain("bnd", 300);
        bnd = '{65025, 0, 255, 256};
        if (r_p.size() >= rbase + 4) begin
            for (int k = 0; k < 4; k++) check("bnd_prod", 32'(r_p[rbase + k]), 32'(bnd[k]));
        end else begin
            check("bnd_count", 32'(r_p.size() - rbase), 32'd4);
        end

        // Reset while RUN counter is 4; the aborted request must never respond.
        gbase = g_id.size();
        rbase = r_p.size();
        push(0, 8'd5, 8'd5);
        n = 0;
        while (g_id.size() == gbase && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("abort_granted", 32'(g_id.size() - gbase), 32'h1);
        t_grant = g_edge[g_edge.size() - 1];
        while (cyc < t_grant + 4) begin
            @(posedge clk);
            #3;
        end
        rst = 1'b1;
        @(posedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
        check_rst_vals("abort");
        gbase = g_id.size();
        push(1, 8'd3, 8'd4);
        push(0, 8'd2, 8'd2);
        wait_drain("abort", 200);
        if (g_id.size() >= gbase + 2) begin
            check("abort_next0", 32'(g_id[gbase]), 32'd0);
            check("abort_next1", 32'(g_id[gbase + 1]), 32'd1);
        end else begin
            check("abort_grants", 32'(g_id.size() - gbase), 32'd2);
        end
        check("abort_rsp_count", 32'(r_p.size() - rbase), 32'd2);
        if (r_p.size() >= rbase + 2) begin
            check("abort_p0", 32'(r_p[rbase]), 32'd4);
            check("abort_p1", 32'(r_p[rbase + 1]), 32'd12);
        end

        // ops_done wrap from 0xFFFF.
        @(posedge clk);
        #3;
        force dut.ops_done = 16'hFFFF;
        exp_ops = 16'hFFFF;
        #1 release dut.ops_done;
        push(2, 8'd3, 8'd3);
        wait_drain("wrap", 100);
        check("wrap_ops", 32'(ops_done), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/binary_mul_sched.md
# binary_mul_sched

Round-robin scheduler that shares one `Binary_mul_8_1_uni` serial 8x8 unsigned multiplier among `NUM_REQ` requesters. Each requester presents an operand pair with a valid/ready handshake. The scheduler grants one requester at a time, loads the operands into the multiplier and waits the multiplier's fixed latency. It then returns the 16-bit product with the requester's ID on a single valid/ready response port. It sits between client logic and the multiplier instance and fully owns the multiplier's operand, enable and reset pins.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `LATENCY`, default 9: multiplier cycles from operand load to valid `P`.
- `IDW`, default `$clog2(NUM_REQ)`: response ID width.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  NUM_REQ  per-requester operand valid.
- `req_a`  in  8*NUM_REQ  operand A; requester i uses bits [8i+7:8i].
- `req_b`  in  8*NUM_REQ  operand B; same packing.
- `req_ready`  out  NUM_REQ  one-hot grant; a transfer occurs on the edge where `req_valid[i]` and `req_ready[i]` are both 1.
- `rsp_valid`  out  1  product available.
- `rsp_ready`  in  1  consumer accepts the product.
- `rsp_id`  out  IDW  index of the requester that owns `rsp_p`.
- `rsp_p`  out  16  unsigned product A*B.
- `mul_a`, `mul_b`  out  8  operands to the multiplier, registered.
- `mul_en`  out  1  multiplier enable.
- `mul_rst_n`  out  1  multiplier reset, equal to `~rst` (combinational).
- `mul_p`  in  16  multiplier product.
- `busy`  out  1  1 in RUN or DONE.
- `ops_done`  out  16  count of completed response handshakes; wraps from 0xFFFF to 0.

## Operation
- FSM states are IDLE, RUN and DONE. Reset puts the FSM in IDLE.
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_p`=0, `mul_a`=`mul_b`=0, `mul_en`=0, `busy`=0, `ops_done`=0. The round-robin pointer resets to `NUM_REQ-1`, so requester 0 has first priority.
- IDLE:
  - `req_ready` is combinational and one-hot. It grants the first asserted `req_valid` scanning from pointer+1 upward, modulo `NUM_REQ`.
  - `req_ready` is all-zero when no request is pending and whenever `rst`=1.
  - On the grant edge: latch `req_a`/`req_b` of the winner into `mul_a`/`mul_b`, latch the winner index into `rsp_id`, set the pointer to the winner, clear the cycle counter, go to RUN.
- RUN:
  - `mul_en`=1, and `mul_a`/`mul_b` are held stable.
  - The counter increments every edge.
  - On the edge where the counter equals `LATENCY`: capture `mul_p` into `rsp_p`, set `rsp_valid`=1, go to DONE.
  - `req_ready` is 0 for the whole state.
- DONE:
  - `rsp_valid`, `rsp_id` and `rsp_p` are held stable until an edge with `rsp_ready`=1.
  - On that edge: `rsp_valid`=0, `ops_done` increments, go to IDLE.
  - No grant is issued in DONE.
- `mul_en` is 0 in IDLE and DONE. `mul_a`/`mul_b` keep their last values outside RUN.
- Requesters not granted keep waiting. Their operands must stay stable while `req_valid` is high; the scheduler never drops a pending request.
- Arithmetic: the product is full 16-bit unsigned with no truncation. 255*255 = 65025 (0xFE01).
- Reset in any state, including mid-RUN or DONE:
  - Return to IDLE on that edge, with all outputs at their reset values.
  - The in-flight result is discarded and no response is produced.
  - `mul_rst_n` is low for the same cycles.

## Timing
- Grant edge is T. `rsp_valid` rises after edge T+LATENCY+1, which is T+10 at the default `LATENCY`.
- With `rsp_ready` held at 1, the handshake occurs at T+LATENCY+2 and the next grant at T+LATENCY+3. Minimum spacing between grants is `LATENCY`+3 = 12 cycles.
- Each stall cycle of `rsp_ready`=0 in DONE adds one cycle to that spacing.
- Round-robin fairness: with all requesters continuously valid, grants cycle 0,1,...,NUM_REQ-1,0,... No requester waits more than NUM_REQ-1 other transactions.
- `busy` is registered and is 1 from the cycle after the grant edge through the response handshake edge.

## Test plan
- Single request: requester 0 sends A=13, B=11 → `req_ready[0]` high one cycle, `rsp_valid` 10 cycles after the grant edge with `rsp_p`=143, `rsp_id`=0, `ops_done`=1.
- All 4 requesters valid continuously with A=i+1, B=10 → grant order 0,1,2,3,0. Products are 10, 20, 30, 40, and grant edges are spaced exactly 12 cycles apart.
- Backpressure: hold `rsp_ready`=0 for 5 cycles in DONE → `rsp_p`/`rsp_id` stable, no `req_ready` asserted; the next grant is 17 cycles after the previous one.
- Boundaries: 255*255 → 65025; 0*200 → 0; 1*255 → 255; 128*2 → 256.
- Reset asserted at RUN counter=4 → next cycle IDLE, outputs at reset values, no response for the aborted request. The next grant goes to requester 0.
- Force `ops_done` to 0xFFFF via 65535 transactions, or via a bench preload hook, then complete one more → `ops_done`=0.
